// File: rtl/ntt_pkg.sv
// Shared constants and types for the q = 2^28 - 2^16 + 1 NTT datapath.
package ntt_pkg;
  typedef logic [27:0] word_t;

  localparam word_t Q           = 28'd268369921;
  localparam int    MULT_LAT    = 4;
  localparam word_t HALF_Q_CEIL = 28'd134184961;
endpackage

// File: rtl/mod_mult_q28.sv
// Pipelined modular multiplier mod q = 2^28 - 2^16 + 1, latency MULT_LAT = 4.
// Solinas folding uses 2^28 == 2^16 - 1 (mod q), then one conditional subtract.
module mod_mult_q28 import ntt_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [27:0] a,
  input  logic [27:0] b,
  output logic        out_valid,
  output logic [27:0] prod
);

  function automatic logic [44:0] fold56(input logic [55:0] v);
    logic [27:0] hi;
    hi = v[55:28];
    return {17'd0, v[27:0]} + {1'b0, hi, 16'd0} - {17'd0, hi};
  endfunction

  function automatic logic [33:0] fold45(input logic [44:0] v);
    logic [16:0] hi;
    hi = v[44:28];
    return {6'd0, v[27:0]} + {1'b0, hi, 16'd0} - {17'd0, hi};
  endfunction

  // Input to this fold is < 2^33, so the result is < 2^28 + 2^21 < 2q.
  function automatic logic [28:0] fold34(input logic [33:0] v);
    logic [5:0] hi;
    hi = v[33:28];
    return {1'b0, v[27:0]} + {7'd0, hi, 16'd0} - {23'd0, hi};
  endfunction

  function automatic word_t csub(input logic [28:0] v);
    logic [28:0] r;
    r = v;
    if (r >= {1'b0, Q}) r = r - {1'b0, Q};
    return word_t'(r);
  endfunction

  logic [55:0] prod_p1;
  logic [44:0] r_p2;
  logic [28:0] r_p3;
  word_t       r_p4;
  logic        vld_p1, vld_p2, vld_p3, vld_p4;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      vld_p4 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
    end
  end

  // p1: full product; p2: first fold; p3: second and third fold; p4: final subtract
  always_ff @(posedge clk) begin
    prod_p1 <= 56'(a) * 56'(b);
    r_p2    <= fold56(prod_p1);
    r_p3    <= fold34(fold45(r_p2));
    r_p4    <= csub(r_p3);
  end

  assign out_valid = vld_p4;
  assign prod      = r_p4;

endmodule

// File: rtl/gs_butterfly.sv
// Gentleman-Sande INTT butterfly: x_out = (x+y) mod q, y_out = ((x-y)*w) mod q.
// Optional GS_HALVE_EN adds a stage multiplying both results by 2^-1 mod q.
module gs_butterfly import ntt_pkg::*; #(
  parameter int    START          = 0,
  parameter int    NFACT          = 16,
  parameter word_t FACTORS [NFACT] = '{default: 28'd1}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [27:0] x_in,
  input  logic [27:0] y_in,
  output logic        out_valid,
  output logic [27:0] x_out,
  output logic [27:0] y_out
);

  localparam int              IDX_W   = (NFACT > 1) ? $clog2(NFACT) : 1;
  localparam logic [7:0]      START_C = 8'(START);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(NFACT - 1);

  function automatic word_t mod_add(input word_t a, input word_t b);
    logic [28:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, Q}) sum = sum - {1'b0, Q};
    return word_t'(sum);
  endfunction

  function automatic word_t mod_sub(input word_t a, input word_t b);
    logic signed [29:0] diff;
    diff = $signed({2'b00, a}) - $signed({2'b00, b});
    if (diff < 0) diff = diff + $signed({2'b00, Q});
    return word_t'(diff);
  endfunction

  logic [7:0]       cnt;
  logic [IDX_W-1:0] idx;
  logic             vld_p1;
  word_t            s_p1, d_p1, w_p1;
  word_t            s_p2, s_p3, s_p4, s_p5;
  logic             vld_p5;
  word_t            prod_p5;
  logic             fin_vld;
  word_t            fin_x, fin_y;

  // Counter saturates at START; only then does the twiddle index walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 8'd0;
      idx    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        if (cnt == START_C) idx <= (idx == LAST) ? '0 : idx + 1'b1;
        else                cnt <= cnt + 8'd1;
      end
    end
  end

  // Stage 1: modular add/sub and twiddle fetch
  always_ff @(posedge clk) begin
    s_p1 <= mod_add(x_in, y_in);
    d_p1 <= mod_sub(x_in, y_in);
    w_p1 <= FACTORS[idx];
  end

  // Stages 2..5: multiplier, with the sum delayed alongside
  mod_mult_q28 u_mult (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld_p1),
    .a         (d_p1),
    .b         (w_p1),
    .out_valid (vld_p5),
    .prod      (prod_p5)
  );

  always_ff @(posedge clk) begin
    s_p2 <= s_p1;
    s_p3 <= s_p2;
    s_p4 <= s_p3;
    s_p5 <= s_p4;
  end

`ifdef GS_HALVE_EN
  function automatic word_t halve(input word_t v);
    return v[0] ? word_t'({1'b0, v[27:1]} + HALF_Q_CEIL) : {1'b0, v[27:1]};
  endfunction

  logic  vld_p6;
  word_t x_p6, y_p6;

  always_ff @(posedge clk) begin
    if (rst) vld_p6 <= 1'b0;
    else     vld_p6 <= vld_p5;
  end

  // Stage 6: halving
  always_ff @(posedge clk) begin
    x_p6 <= halve(s_p5);
    y_p6 <= halve(prod_p5);
  end

  assign fin_vld = vld_p6;
  assign fin_x   = x_p6;
  assign fin_y   = y_p6;
`else
  assign fin_vld = vld_p5;
  assign fin_x   = s_p5;
  assign fin_y   = prod_p5;
`endif

  // Output stage: data holds across idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
    end else begin
      out_valid <= fin_vld;
      if (fin_vld) begin
        x_out <= fin_x;
        y_out <= fin_y;
      end
    end
  end

endmodule

// File: tb/tb_gs_butterfly.sv
// Scoreboard bench for gs_butterfly: two instances (START=2 and START=0) share one stimulus stream.
module tb_gs_butterfly;
  import ntt_pkg::*;

`ifdef GS_HALVE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif
  localparam longint unsigned QL = 64'd268369921;
  localparam logic [27:0] FACT_TB [16] = '{28'd1, 28'd2, 28'd3, 28'd4, 28'd5, 28'd6, 28'd7, 28'd8,
                                          28'd9, 28'd10, 28'd11, 28'd12, 28'd13, 28'd14, 28'd15, 28'd16};
  localparam int START_M [2] = '{2, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [27:0] x_in = '0;
  logic [27:0] y_in = '0;
  logic        va, vb;
  logic [27:0] xa, ya, xb, yb;

  always #5 clk = ~clk;

  gs_butterfly #(.START(2), .NFACT(16), .FACTORS(FACT_TB)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .y_in(y_in),
    .out_valid(va), .x_out(xa), .y_out(ya));

  gs_butterfly #(.START(0), .NFACT(16), .FACTORS(FACT_TB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .y_in(y_in),
    .out_valid(vb), .x_out(xb), .y_out(yb));

  typedef struct {
    logic [27:0] x;
    logic [27:0] y;
    int          due;
  } exp_t;

  exp_t        sq [2][$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          mon_en = 1'b0;
  logic [27:0] lx [2];
  logic [27:0] ly [2];
  int          cnt_m [2];
  int          idx_m [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint unsigned halve_m(input longint unsigned v);
    return (v % 2 == 0) ? v / 2 : (v + QL) / 2;
  endfunction

  task automatic check(input string name, input longint got, input longint req);
    n_chk++;
    if (got == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, req, cyc);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cnt_m[d] = 0;
      idx_m[d] = 0;
      lx[d] = '0;
      ly[d] = '0;
      sq[d].delete();
    end
  endtask

  task automatic beat(input logic v, input logic [27:0] x, input logic [27:0] y);
    longint unsigned xe, ye, w;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    x_in = x;
    y_in = y;
    if (v) begin
      for (int d = 0; d < 2; d++) begin
        w  = 64'(FACT_TB[idx_m[d]]);
        xe = (64'(x) + 64'(y)) % QL;
        ye = (((64'(x) + QL - 64'(y)) % QL) * w) % QL;
`ifdef GS_HALVE_EN
        xe = halve_m(xe);
        ye = halve_m(ye);
`endif
        e.x = 28'(xe);
        e.y = 28'(ye);
        e.due = cyc + LAT;
        sq[d].push_back(e);
        if (cnt_m[d] == START_M[d]) idx_m[d] = (idx_m[d] + 1) % 16;
        else cnt_m[d]++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 28'd0, 28'd0);
  endtask

  // Reset for one cycle; optionally present a beat that must be dropped.
  task automatic do_reset(input logic with_beat);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = with_beat;
    x_in = 28'd7;
    y_in = 28'd3;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_a_valid", va, 0);
    check("rst_b_valid", vb, 0);
    check("rst_a_y", ya, 0);
  endtask

  task automatic mon_one(input int d, input logic v, input logic [27:0] x, input logic [27:0] y);
    exp_t e;
    string tag;
    tag = (d == 0) ? "a" : "b";
    if (v) begin
      if (sq[d].size() == 0) begin
        check({tag, "_unexpected_valid"}, v, 0);
      end else begin
        e = sq[d].pop_front();
        check({tag, "_latency"}, cyc, e.due);
        check({tag, "_x_out"}, x, e.x);
        check({tag, "_y_out"}, y, e.y);
      end
      lx[d] = x;
      ly[d] = y;
    end else begin
      check({tag, "_hold_x"}, x, lx[d]);
      check({tag, "_hold_y"}, y, ly[d]);
    end
    if (sq[d].size() > 0 && sq[d][0].due < cyc) begin
      e = sq[d].pop_front();
      check({tag, "_missing_output_due"}, cyc, e.due);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_one(0, va, xa, ya);
      mon_one(1, vb, xb, yb);
    end
  end

  initial begin
    logic [6:0] pat;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("init_a_valid", va, 0);
    check("init_a_x", xa, 0);
    check("init_a_y", ya, 0);
    check("init_b_valid", vb, 0);
    check("init_b_x", xb, 0);
    check("init_b_y", yb, 0);
    mon_en = 1'b1;

    // Basic add/sub, including q-1 boundary operands
    beat(1'b1, 28'd5, 28'd3);
    idle(8);
    beat(1'b1, 28'd1, 28'd2);
    beat(1'b1, 28'd268369920, 28'd268369920);
    idle(8);

    // Twiddle walk with index wrap
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) beat(1'b1, 28'd0, 28'd1);
    idle(8);

    // Bubbles: valid pattern 1,0,0,1,1,0,1
    do_reset(1'b0);
    pat = 7'b1011001;
    for (int i = 0; i < 7; i++) beat(pat[i], 28'(100 + i), 28'd1);
    idle(8);

    // Reset mid-stream, with a beat presented during reset that must be dropped
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) beat(1'b1, 28'(10 + 3 * i), 28'(i));
    do_reset(1'b1);
    beat(1'b1, 28'd9, 28'd4);
    beat(1'b1, 28'd9, 28'd4);
    idle(8);

    // Boundary and mixed operands
    beat(1'b1, 28'd268369920, 28'd0);
    beat(1'b1, 28'd0, 28'd268369920);
    beat(1'b1, 28'd268369920, 28'd1);
    beat(1'b1, 28'd123456789, 28'd234567890);
    beat(1'b1, 28'd1, 28'd0);
    idle(10);

    check("drain_a", sq[0].size(), 0);
    check("drain_b", sq[1].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
